freq_compare_mc: RTL and testbench
==================================

// Module: freq_compare_mc
// PURPOSE
//  Multi-channel successor to the single-pair count comparator. Compares one reference
//  window count against NCH divided-clock counts when a measurement window closes.
//  Per channel: ref_faster/div_faster direction, signed error, and a hysteretic lock state.
//  Sits between the window counters and the calibration controllers.
//  Tolerance is programmable at run time.
// PARAMETERS
//  NCH         4   number of divided-clock channels
//  COUNT_WIDTH 16  width of each window count
//  MIN_SAMPLES 50  ref_count below this = no valid measurement
//  LOCK_CNT    5   consecutive in-band samples needed to lock (1..2^HYS_W-1)
//  UNLOCK_CNT  3   consecutive out-of-band samples needed to unlock (1..2^HYS_W-1)
//  HYS_W       4   width of per-channel hysteresis counters
// PORTS
//  clk          in  1               clock
//  rst_n        in  1               async active-low reset
//  sample_valid in  1               one-cycle strobe; counts valid this cycle
//  clear        in  1               sync clear of all channel state
//  thresh       in  COUNT_WIDTH     unsigned tolerance, sampled with sample_valid
//  ref_count    in  COUNT_WIDTH     reference window count
//  div_count    in  NCH*COUNT_WIDTH ch k = bits [k*CW +: CW]
//  result_valid out 1               one-cycle strobe, outputs updated
//  ref_faster   out NCH             diff > thresh on last sample
//  div_faster   out NCH             diff < -thresh on last sample
//  locked       out NCH             channel in LOCKED state
//  lock_lost    out NCH             sticky: channel left LOCKED; cleared by clear
//  err          out NCH*(CW+1)      signed ref-div per channel, held between samples
// BEHAVIOUR
//  Reset: all outputs 0, all channels ACQ, all hysteresis counters 0.
//  Latency: outputs and result_valid update on the clk edge after sample_valid.
//   result_valid is high exactly 1 cycle. All outputs hold between samples.
//  Arithmetic:
//   diff = {0,ref} - {0,div_k}, signed CW+1.
//   Compare against +/-thresh in CW+2 signed. No overflow at any count or thresh value.
//   In-band: -thresh <= diff <= thresh. Equality to the bound counts as in-band.
//  Per-sample classification, priority order:
//   ref_count < MIN_SAMPLES: NOSIG. All ref_faster/div_faster = 0, err = 0.
//   diff > thresh: FAST. ref_faster = 1, div_faster = 0.
//   diff < -thresh: SLOW. ref_faster = 0, div_faster = 1.
//   else: INBAND. ref_faster = 0, div_faster = 0.
//  Per-channel FSM, updated only when sample_valid is high:
//   ACQ (locked = 0):
//    INBAND increments good_cnt.
//    When good_cnt+1 == LOCK_CNT, go to LOCKED. locked = 1 in the same result.
//    FAST, SLOW or NOSIG sets good_cnt = 0.
//   LOCKED (locked = 1):
//    FAST or SLOW increments bad_cnt.
//    INBAND sets bad_cnt = 0.
//    When bad_cnt+1 == UNLOCK_CNT, go to ACQ with locked = 0, lock_lost = 1, counters 0.
//    NOSIG goes to ACQ immediately, with lock_lost = 1 and counters 0.
//  Channels are fully independent; one sample may lock one channel and unlock another.
//  Counters never wrap: they stop at their terminal value because the FSM transitions there.
//  clear:
//   Resets every channel to ACQ, clears counters, flags, err and lock_lost.
//   clear with sample_valid in the same cycle: clear wins, sample dropped, result_valid = 0.
//  Async reset mid-window: all state returns to reset values immediately.
//  The first result comes from the next sample_valid after reset deasserts.
//  thresh changes take effect only at a sample_valid edge. Lock state is never re-evaluated
//  retroactively.
// TESTING
//  1. ref=1000, div_k=1000 x 5 samples, thresh=2:
//     locked rises on sample 5, not sample 4; ref/div_faster stay 0.
//  2. Locked ch0; then div0=990 (diff=+10) x 3:
//     ref_faster=1 each sample, locked falls on sample 3, lock_lost[0]=1 held until clear.
//  3. Bound check, thresh=2: diff=+2 and -2 -> INBAND;
//     +3 -> ref_faster; -3 -> div_faster; err = +3 / -3.
//  4. ref=49: all channels NOSIG, err=0, locked channel drops with lock_lost.
//     ref=0, div=FFFF: no overflow, NOSIG.
//  5. ref=FFFF, div=0, thresh=FFFF:
//     INBAND, err=+65535; thresh=0, diff=0 -> INBAND.
//  6. clear and sample_valid in the same cycle: no result_valid, all state 0.
//     Reset asserted mid-lock -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/freq_compare_mc_if.sv
// Bundle between the window counters, the comparator and the calibration controllers.
// The slave modport is the comparator side; the master drives the counts.
interface freq_compare_mc_if #(
  parameter int NCH         = 4,
  parameter int COUNT_WIDTH = 16
);
    logic                             sample_valid;
    logic                             clear;
    logic [COUNT_WIDTH-1:0]           thresh;
    logic [COUNT_WIDTH-1:0]           ref_count;
    logic [NCH*COUNT_WIDTH-1:0]       div_count;
    logic                             result_valid;
    logic [NCH-1:0]                   ref_faster;
    logic [NCH-1:0]                   div_faster;
    logic [NCH-1:0]                   locked;
    logic [NCH-1:0]                   lock_lost;
    logic [NCH*(COUNT_WIDTH+1)-1:0]   err;

    modport master (
        output sample_valid, clear, thresh, ref_count, div_count,
        input  result_valid, ref_faster, div_faster, locked, lock_lost, err
    );

    modport slave (
        input  sample_valid, clear, thresh, ref_count, div_count,
        output result_valid, ref_faster, div_faster, locked, lock_lost, err
    );
endinterface

// File: rtl/freq_compare_mc.sv
// Compares one reference window count against NCH divided-clock counts and tracks a
// hysteretic per-channel lock state; results are registered one cycle after sample_valid.
module freq_compare_mc #(
    parameter int NCH         = 4,
    parameter int COUNT_WIDTH = 16,
    parameter int MIN_SAMPLES = 50,
    parameter int LOCK_CNT    = 5,
    parameter int UNLOCK_CNT  = 3,
    parameter int HYS_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    freq_compare_mc_if.slave   bus
);
    localparam int CW = COUNT_WIDTH;

    localparam logic [1:0] CLS_INBAND = 2'd0;
    localparam logic [1:0] CLS_FAST   = 2'd1;
    localparam logic [1:0] CLS_SLOW   = 2'd2;
    localparam logic [1:0] CLS_NOSIG  = 2'd3;

    localparam logic [0:0] ST_ACQ    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [HYS_W:0] LOCK_TERM   = (HYS_W+1)'(LOCK_CNT);
    localparam logic [HYS_W:0] UNLOCK_TERM = (HYS_W+1)'(UNLOCK_CNT);

    function automatic logic signed [CW:0] count_diff(input logic [CW-1:0] a,
                                                      input logic [CW-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    // One extra bit over the diff so -thresh never overflows, even at thresh = all ones.
    function automatic logic [1:0] classify(input logic signed [CW:0] diff,
                                            input logic [CW-1:0]     thr,
                                            input logic              nosig);
        logic signed [CW+1:0] d_ext;
        logic signed [CW+1:0] t_pos;
        logic signed [CW+1:0] t_neg;
        d_ext = {diff[CW], diff};
        t_pos = $signed({2'b00, thr});
        t_neg = -t_pos;
        if (nosig)              return CLS_NOSIG;
        else if (d_ext > t_pos) return CLS_FAST;
        else if (d_ext < t_neg) return CLS_SLOW;
        else                    return CLS_INBAND;
    endfunction

    logic nosig;
    logic result_valid_q, result_valid_d;

    assign nosig = bus.ref_count < CW'(MIN_SAMPLES);

    always_comb begin
        result_valid_d = bus.sample_valid & ~bus.clear;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) result_valid_q <= 1'b0;
        else        result_valid_q <= result_valid_d;
    end

    assign bus.result_valid = result_valid_q;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [0:0]           st_q,   st_d;
        logic [HYS_W-1:0]     good_q, good_d;
        logic [HYS_W-1:0]     bad_q,  bad_d;
        logic                 rf_q,   rf_d;
        logic                 df_q,   df_d;
        logic                 lost_q, lost_d;
        logic signed [CW:0]   err_q,  err_d;
        logic signed [CW:0]   diff;
        logic [1:0]           cls;
        logic                 off_band;

        assign diff     = count_diff(bus.ref_count, bus.div_count[k*CW +: CW]);
        assign cls      = classify(diff, bus.thresh, nosig);
        assign off_band = (cls == CLS_FAST) || (cls == CLS_SLOW);

        always_comb begin
            st_d   = st_q;
            good_d = good_q;
            bad_d  = bad_q;
            rf_d   = rf_q;
            df_d   = df_q;
            lost_d = lost_q;
            err_d  = err_q;
            if (bus.clear) begin
                st_d   = ST_ACQ;
                good_d = '0;
                bad_d  = '0;
                rf_d   = 1'b0;
                df_d   = 1'b0;
                lost_d = 1'b0;
                err_d  = '0;
            end else if (bus.sample_valid) begin
                rf_d  = (cls == CLS_FAST);
                df_d  = (cls == CLS_SLOW);
                err_d = nosig ? '0 : diff;
                case (st_q)
                    ST_ACQ: begin
                        if (cls == CLS_INBAND) begin
                            if (({1'b0, good_q} + (HYS_W+1)'(1)) == LOCK_TERM) begin
                                st_d   = ST_LOCKED;
                                good_d = '0;
                                bad_d  = '0;
                            end else begin
                                good_d = good_q + HYS_W'(1);
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                    default: begin
                        if ((cls == CLS_NOSIG) ||
                            (off_band && (({1'b0, bad_q} + (HYS_W+1)'(1)) == UNLOCK_TERM))) begin
                            st_d   = ST_ACQ;
                            lost_d = 1'b1;
                            good_d = '0;
                            bad_d  = '0;
                        end else if (off_band) begin
                            bad_d = bad_q + HYS_W'(1);
                        end else begin
                            bad_d = '0;
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q   <= ST_ACQ;
                good_q <= '0;
                bad_q  <= '0;
                rf_q   <= 1'b0;
                df_q   <= 1'b0;
                lost_q <= 1'b0;
                err_q  <= '0;
            end else begin
                st_q   <= st_d;
                good_q <= good_d;
                bad_q  <= bad_d;
                rf_q   <= rf_d;
                df_q   <= df_d;
                lost_q <= lost_d;
                err_q  <= err_d;
            end
        end

        assign bus.ref_faster[k]               = rf_q;
        assign bus.div_faster[k]               = df_q;
        assign bus.locked[k]                   = (st_q == ST_LOCKED);
        assign bus.lock_lost[k]                = lost_q;
        assign bus.err[k*(CW+1) +: (CW+1)]     = err_q;
    end

endmodule

// File: tb/tb_freq_compare_mc.sv
// Scoreboard bench for freq_compare_mc: a behavioural model predicts each result,
// a negedge monitor checks every presented result and that outputs hold in between.
module tb_freq_compare_mc;
    localparam int NCH        = 4;
    localparam int CW         = 16;
    localparam int MIN_S      = 50;
    localparam int LOCK_CNT   = 5;
    localparam int UNLOCK_CNT = 3;

    typedef struct packed {
        logic [NCH-1:0]          rf;
        logic [NCH-1:0]          df;
        logic [NCH-1:0]          lk;
        logic [NCH-1:0]          lost;
        logic [NCH*(CW+1)-1:0]   err;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    freq_compare_mc_if #(.NCH(NCH), .COUNT_WIDTH(CW)) bus();

    freq_compare_mc #(
        .NCH(NCH), .COUNT_WIDTH(CW), .MIN_SAMPLES(MIN_S),
        .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .HYS_W(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    res_t exp_q[$];
    res_t hold = '0;
    int   tests = 0;
    int   fails = 0;
    int   m_locked[NCH];
    int   m_streak[NCH];
    int   m_lost[NCH];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag, input res_t e);
        check({tag, "_ref_faster"}, 128'(bus.ref_faster), 128'(e.rf));
        check({tag, "_div_faster"}, 128'(bus.div_faster), 128'(e.df));
        check({tag, "_locked"},     128'(bus.locked),     128'(e.lk));
        check({tag, "_lock_lost"},  128'(bus.lock_lost),  128'(e.lost));
        check({tag, "_err"},        128'(bus.err),        128'(e.err));
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_locked[k] = 0;
            m_streak[k] = 0;
            m_lost[k]   = 0;
        end
        hold = '0;
    endtask

    function automatic logic [NCH*CW-1:0] all_div(input logic [CW-1:0] v);
        return {NCH{v}};
    endfunction

    task automatic scramble_inputs();
        bus.ref_count = CW'($urandom);
        bus.div_count = {NCH{CW'($urandom)}};
        bus.thresh    = CW'($urandom);
    endtask

    // Reference model: signed difference in plain integers, one streak counter per channel.
    task automatic issue(input logic [CW-1:0] r, input logic [NCH*CW-1:0] divs,
                         input logic [CW-1:0] thr, input int gap);
        res_t e;
        int   d;
        int   dv;
        bit   ns, fast, slow, inb;
        logic [31:0] d32;
        e = '0;
        for (int k = 0; k < NCH; k++) begin
            dv   = int'(divs[k*CW +: CW]);
            d    = int'(r) - dv;
            ns   = int'(r) < MIN_S;
            fast = !ns && (d > int'(thr));
            slow = !ns && (d < -int'(thr));
            inb  = !ns && !fast && !slow;
            d32  = d;
            e.rf[k] = fast;
            e.df[k] = slow;
            e.err[k*(CW+1) +: (CW+1)] = ns ? '0 : d32[CW:0];
            if (m_locked[k] == 0) begin
                if (inb) begin
                    m_streak[k]++;
                    if (m_streak[k] == LOCK_CNT) begin
                        m_locked[k] = 1;
                        m_streak[k] = 0;
                    end
                end else begin
                    m_streak[k] = 0;
                end
            end else if (ns) begin
                m_locked[k] = 0;
                m_lost[k]   = 1;
                m_streak[k] = 0;
            end else if (fast || slow) begin
                m_streak[k]++;
                if (m_streak[k] == UNLOCK_CNT) begin
                    m_locked[k] = 0;
                    m_lost[k]   = 1;
                    m_streak[k] = 0;
                end
            end else begin
                m_streak[k] = 0;
            end
            e.lk[k]   = (m_locked[k] != 0);
            e.lost[k] = (m_lost[k] != 0);
        end
        exp_q.push_back(e);
        bus.ref_count    = r;
        bus.div_count    = divs;
        bus.thresh       = thr;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        scramble_inputs();
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear(input bit with_sample);
        bus.clear        = 1'b1;
        bus.sample_valid = with_sample;
        bus.ref_count    = 16'd1000;
        bus.div_count    = all_div(16'd1000);
        bus.thresh       = 16'd2;
        @(posedge clk);
        #1;
        bus.clear        = 1'b0;
        bus.sample_valid = 1'b0;
        model_reset();
    endtask

    task automatic do_reset();
        @(negedge clk);
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b0;
        #1;
        check("async_rst_locked",       128'(bus.locked),       128'(0));
        check("async_rst_lock_lost",    128'(bus.lock_lost),    128'(0));
        check("async_rst_err",          128'(bus.err),          128'(0));
        check("async_rst_result_valid", 128'(bus.result_valid), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result_valid: got 1, want 0 at %0t", $time);
                end else begin
                    hold = exp_q.pop_front();
                    compare_all("result", hold);
                end
            end else begin
                compare_all("hold", hold);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [NCH*CW-1:0] dv;
        logic [CW-1:0]     r;
        logic [CW-1:0]     thr;
        int                sel;
        bus.sample_valid = 1'b0;
        bus.clear        = 1'b0;
        bus.thresh       = '0;
        bus.ref_count    = '0;
        bus.div_count    = '0;
        model_reset();
        #1;
        check("reset_result_valid", 128'(bus.result_valid), 128'(0));
        check("reset_locked",       128'(bus.locked),       128'(0));
        check("reset_err",          128'(bus.err),          128'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Lock after exactly five in-band samples
        for (int i = 0; i < 5; i++) begin
            issue(16'd1000, all_div(16'd1000), 16'd2, 0);
            if (i == 3) check("t1_unlocked_s4", 128'(bus.locked), 128'(4'h0));
        end
        check("t1_locked_s5", 128'(bus.locked), 128'(4'hF));
        check("t1_no_dir",    128'({bus.ref_faster, bus.div_faster}), 128'(0));

        // Three FAST samples on ch0 drop the lock and set sticky lock_lost
        for (int i = 0; i < 3; i++) begin
            issue(16'd1000, {16'd1000, 16'd1000, 16'd1000, 16'd990}, 16'd2, 1);
            check("t2_ref_faster0", 128'(bus.ref_faster[0]), 128'(1));
        end
        check("t2_locked",    128'(bus.locked),    128'(4'hE));
        check("t2_lock_lost", 128'(bus.lock_lost), 128'(4'h1));
        repeat (4) @(posedge clk);
        #1;
        check("t2_lost_sticky", 128'(bus.lock_lost), 128'(4'h1));

        // Band edges: +2,-2 in band; +3 fast; -3 slow
        issue(16'd1000, {16'd1003, 16'd997, 16'd1002, 16'd998}, 16'd2, 0);
        check("t3_ref_faster", 128'(bus.ref_faster), 128'(4'b0100));
        check("t3_div_faster", 128'(bus.div_faster), 128'(4'b1000));
        check("t3_err_p3", 128'(bus.err[2*(CW+1) +: (CW+1)]), 128'(17'h00003));
        check("t3_err_m3", 128'(bus.err[3*(CW+1) +: (CW+1)]), 128'(17'h1FFFD));

        // NOSIG while locked
        do_clear(1'b0);
        for (int i = 0; i < 5; i++) issue(16'd800, all_div(16'd800), 16'd1, 0);
        issue(16'd49, all_div(16'd40), 16'd1, 0);
        check("t4_locked",    128'(bus.locked),    128'(0));
        check("t4_lock_lost", 128'(bus.lock_lost), 128'(4'hF));
        check("t4_err",       128'(bus.err),       128'(0));
        issue(16'd0, all_div(16'hFFFF), 16'd0, 0);
        check("t4_nosig_dir", 128'({bus.ref_faster, bus.div_faster}), 128'(0));

        // Extremes
        issue(16'hFFFF, all_div(16'd0), 16'hFFFF, 0);
        check("t5_inband", 128'({bus.ref_faster, bus.div_faster}), 128'(0));
        check("t5_err_max", 128'(bus.err[0 +: (CW+1)]), 128'(17'h0FFFF));
        issue(16'd500, all_div(16'd500), 16'd0, 0);
        check("t5_thr0", 128'({bus.ref_faster, bus.div_faster}), 128'(0));

        // Clear beats a coincident sample; reset while locked
        for (int i = 0; i < 5; i++) issue(16'd700, all_div(16'd701), 16'd1, 0);
        do_clear(1'b1);
        check("t6_clear_locked", 128'(bus.locked),    128'(0));
        check("t6_clear_lost",   128'(bus.lock_lost), 128'(0));
        check("t6_clear_err",    128'(bus.err),       128'(0));
        check("t6_clear_rv",     128'(bus.result_valid), 128'(0));
        for (int i = 0; i < 6; i++) issue(16'd700, all_div(16'd699), 16'd1, 0);
        do_reset();

        // Randomised traffic around lock conditions
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 3) begin
                do_clear($urandom_range(0, 1) == 1);
            end else if (sel < 5) begin
                do_reset();
            end else begin
                if (sel < 12)      r = CW'($urandom_range(0, MIN_S - 1));
                else if (sel < 18) r = CW'($urandom);
                else               r = CW'($urandom_range(100, 3000));
                thr = (sel > 95) ? CW'($urandom) : CW'($urandom_range(0, 4));
                for (int k = 0; k < NCH; k++) begin
                    if ($urandom_range(0, 9) == 0) dv[k*CW +: CW] = CW'($urandom);
                    else dv[k*CW +: CW] = CW'(int'(r) + $urandom_range(0, 8) - 4);
                end
                issue(r, dv, thr, $urandom_range(0, 2));
            end
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
